// File: rtl/lane_cnt_pkg.sv
// lane_cnt_pkg: lane FSM state type, parameter limits and a popcount helper
package lane_cnt_pkg;

    typedef enum logic [1:0] {IDLE, QUAL, OCCUPIED} lane_state_t;

    localparam int MAX_LANES    = 16;
    localparam int MIN_CNT_W    = 2;
    localparam int MAX_CNT_W    = 16;
    localparam int MAX_MIN_HIGH = 255;
    localparam int QUAL_W       = 8;
    localparam int POP_W        = 5;

    function automatic logic [POP_W-1:0] popcount(input logic [MAX_LANES-1:0] v);
        logic [POP_W-1:0] n;
        n = '0;
        for (int k = 0; k < MAX_LANES; k++) n = n + POP_W'(v[k]);
        return n;
    endfunction

endpackage

// File: rtl/lane_qual.sv
// lane_qual: one lane's qualification FSM, qual counter, vehicle count and sticky overflow
module lane_qual
    import lane_cnt_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int MIN_HIGH = 2,
    parameter int SATURATE = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sensor,
    input  logic             clr,
    output logic             hit,
    output logic [CNT_W-1:0] cnt,
    output logic             evt,
    output logic             ovf
);

    localparam logic [QUAL_W-1:0] MH = QUAL_W'(MIN_HIGH);

    lane_state_t       state, state_nxt;
    logic [QUAL_W-1:0] qcnt, qcnt_inc;

    assign qcnt_inc = qcnt + QUAL_W'(1);

    // state register and run length of consecutive high samples while qualifying
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            qcnt  <= '0;
        end else begin
            state <= state_nxt;
            qcnt  <= (sensor && state != OCCUPIED) ? (state == IDLE ? QUAL_W'(1) : qcnt_inc) : '0;
        end
    end

    // next state: a low sample always returns to IDLE, clr never affects the FSM
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     state_nxt = sensor ? (MIN_HIGH == 1 ? OCCUPIED : QUAL) : IDLE;
            QUAL:     state_nxt = !sensor ? IDLE : (qcnt_inc == MH ? OCCUPIED : QUAL);
            OCCUPIED: state_nxt = sensor ? OCCUPIED : IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // qualification fires on the MIN_HIGH-th consecutive high sample
    always_comb begin
        hit = 1'b0;
        if (sensor) hit = (state == IDLE && MIN_HIGH == 1) || (state == QUAL && qcnt_inc == MH);
    end

    // event pulse, lane count and overflow; clr wins over a same-cycle event
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            evt <= 1'b0;
            cnt <= '0;
            ovf <= 1'b0;
        end else begin
            evt <= hit;
            if (clr) begin
                cnt <= '0;
                ovf <= 1'b0;
            end else if (hit) begin
                cnt <= (&cnt && SATURATE != 0) ? cnt : cnt + CNT_W'(1);
                ovf <= ovf | &cnt;
            end
        end
    end

endmodule

// File: rtl/lane_car_counter.sv
// lane_car_counter: multi-lane vehicle counter with all-lane total; LANE_CNT_SYNC_EN adds 2-flop sensor synchronisers
module lane_car_counter
    import lane_cnt_pkg::*;
#(
    parameter int NUM_LANES = 3,
    parameter int CNT_W     = 8,
    parameter int MIN_HIGH  = 2,
    parameter int SATURATE  = 1,
    parameter int TOT_W     = CNT_W + 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_LANES-1:0]       sensor,
    input  logic [NUM_LANES-1:0]       clr,
    input  logic                       clr_total,
    output logic [NUM_LANES*CNT_W-1:0] car_cnt,
    output logic [NUM_LANES-1:0]       car_evt,
    output logic [NUM_LANES-1:0]       ovf,
    output logic [TOT_W-1:0]           total_cnt
);

    if (NUM_LANES < 1 || NUM_LANES > MAX_LANES) begin : g_bad_lanes
        $error("NUM_LANES out of range");
    end
    if (CNT_W < MIN_CNT_W || CNT_W > MAX_CNT_W) begin : g_bad_cnt_w
        $error("CNT_W out of range");
    end
    if (MIN_HIGH < 1 || MIN_HIGH > MAX_MIN_HIGH) begin : g_bad_min_high
        $error("MIN_HIGH out of range");
    end

    logic [NUM_LANES-1:0] sensor_q, hit;
    logic [POP_W-1:0]     evt_n;
    logic [TOT_W+4:0]     sum;

`ifdef LANE_CNT_SYNC_EN
    logic [NUM_LANES-1:0] sync_1, sync_2;

    // two-flop synchroniser per sensor bit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_1 <= '0;
            sync_2 <= '0;
        end else begin
            sync_1 <= sensor;
            sync_2 <= sync_1;
        end
    end

    assign sensor_q = sync_2;
`else
    assign sensor_q = sensor;
`endif

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        lane_qual #(
            .CNT_W    (CNT_W),
            .MIN_HIGH (MIN_HIGH),
            .SATURATE (SATURATE)
        ) u_lane (
            .clk     (clk),
            .reset_n (reset_n),
            .sensor  (sensor_q[i]),
            .clr     (clr[i]),
            .hit     (hit[i]),
            .cnt     (car_cnt[i*CNT_W +: CNT_W]),
            .evt     (car_evt[i]),
            .ovf     (ovf[i])
        );
    end

    assign evt_n = popcount(MAX_LANES'(hit));
    assign sum   = (TOT_W+5)'(total_cnt) + (TOT_W+5)'(evt_n);

    // total of qualified vehicles, saturating; clr_total discards same-cycle events
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) total_cnt <= '0;
        else if (clr_total) total_cnt <= '0;
        else total_cnt <= |sum[TOT_W+4:TOT_W] ? '1 : sum[TOT_W-1:0];
    end

endmodule

// File: tb/tb_lane_car_counter.sv
// tb_lane_car_counter: table vectors, directed corner sequences and randomized model comparison
module tb_lane_car_counter;

    localparam int NL = 3, CW = 8, MH = 2, TW = CW + 2;
    localparam int CMAX = (1 << CW) - 1, TMAX = (1 << TW) - 1;

    logic clk = 1'b0, reset_n = 1'b0, clr_total = 1'b0;
    logic [NL-1:0] sensor = '0, clr = '0;
    logic [NL*CW-1:0] car_cnt, car_cnt_w;
    logic [NL-1:0] car_evt, car_evt_w, ovf, ovf_w;
    logic [TW-1:0] total_cnt, total_cnt_w;

    always #5 clk = ~clk;

    lane_car_counter #(.NUM_LANES(NL), .CNT_W(CW), .MIN_HIGH(MH), .SATURATE(1), .TOT_W(TW)) dut (
        .clk(clk), .reset_n(reset_n), .sensor(sensor), .clr(clr), .clr_total(clr_total),
        .car_cnt(car_cnt), .car_evt(car_evt), .ovf(ovf), .total_cnt(total_cnt));

    lane_car_counter #(.NUM_LANES(NL), .CNT_W(CW), .MIN_HIGH(MH), .SATURATE(0), .TOT_W(TW)) dut_w (
        .clk(clk), .reset_n(reset_n), .sensor(sensor), .clr(clr), .clr_total(clr_total),
        .car_cnt(car_cnt_w), .car_evt(car_evt_w), .ovf(ovf_w), .total_cnt(total_cnt_w));

    int vecs = 0, errs = 0;

    int run[NL], mcnt_s[NL], mcnt_w[NL], mtot;
    bit mevt[NL], movf[NL];

    typedef struct {
        logic [NL-1:0]    s;
        logic [NL-1:0]    c;
        logic             ct;
        logic [NL*CW-1:0] cnt;
        logic [NL-1:0]    evt;
        logic [TW-1:0]    tot;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        vecs++;
        if (a !== e) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", n, a, e);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NL; i++) begin
            run[i] = 0; mcnt_s[i] = 0; mcnt_w[i] = 0; mevt[i] = 0; movf[i] = 0;
        end
        mtot = 0;
    endtask

    task automatic model_step(input logic [NL-1:0] s, input logic [NL-1:0] c, input logic ct);
        int pc = 0;
        for (int i = 0; i < NL; i++) begin
            run[i] = s[i] ? run[i] + 1 : 0;
            mevt[i] = (run[i] == MH);
            if (mevt[i]) pc++;
            if (c[i]) begin
                mcnt_s[i] = 0; mcnt_w[i] = 0; movf[i] = 0;
            end else if (mevt[i]) begin
                if (mcnt_s[i] == CMAX) movf[i] = 1;
                else mcnt_s[i]++;
                mcnt_w[i] = (mcnt_w[i] + 1) % (CMAX + 1);
            end
        end
        mtot = ct ? 0 : (mtot + pc > TMAX ? TMAX : mtot + pc);
    endtask

    task automatic step(input logic [NL-1:0] s, input logic [NL-1:0] c, input logic ct);
        sensor = s; clr = c; clr_total = ct;
        @(posedge clk);
        model_step(s, c, ct);
        #1;
    endtask

    task automatic compare_model();
        for (int i = 0; i < NL; i++) begin
            chk($sformatf("rnd_cnt_sat[%0d]", i), 32'(car_cnt[i*CW +: CW]), 32'(mcnt_s[i]));
            chk($sformatf("rnd_cnt_wrap[%0d]", i), 32'(car_cnt_w[i*CW +: CW]), 32'(mcnt_w[i]));
            chk($sformatf("rnd_evt[%0d]", i), 32'(car_evt[i]), 32'(mevt[i]));
            chk($sformatf("rnd_evt_w[%0d]", i), 32'(car_evt_w[i]), 32'(mevt[i]));
            chk($sformatf("rnd_ovf[%0d]", i), 32'(ovf[i]), 32'(movf[i]));
            chk($sformatf("rnd_ovf_w[%0d]", i), 32'(ovf_w[i]), 32'(movf[i]));
        end
        chk("rnd_total", 32'(total_cnt), 32'(mtot));
        chk("rnd_total_w", 32'(total_cnt_w), 32'(mtot));
    endtask

    task automatic chk_zero(input string n);
        chk({n, "_cnt"}, 32'(car_cnt), 0);
        chk({n, "_evt"}, 32'(car_evt), 0);
        chk({n, "_ovf"}, 32'(ovf), 0);
        chk({n, "_total"}, 32'(total_cnt), 0);
    endtask

    initial begin
        logic [NL-1:0] rs;
        int tot0;

        tbl[0]  = '{3'b001, 3'b000, 1'b0, 24'h000000, 3'b000, 10'd0};
        tbl[1]  = '{3'b000, 3'b000, 1'b0, 24'h000000, 3'b000, 10'd0};
        tbl[2]  = '{3'b010, 3'b000, 1'b0, 24'h000000, 3'b000, 10'd0};
        tbl[3]  = '{3'b010, 3'b000, 1'b0, 24'h000100, 3'b010, 10'd1};
        tbl[4]  = '{3'b010, 3'b000, 1'b0, 24'h000100, 3'b000, 10'd1};
        tbl[5]  = '{3'b010, 3'b000, 1'b0, 24'h000100, 3'b000, 10'd1};
        tbl[6]  = '{3'b010, 3'b000, 1'b0, 24'h000100, 3'b000, 10'd1};
        tbl[7]  = '{3'b000, 3'b000, 1'b1, 24'h000100, 3'b000, 10'd0};
        tbl[8]  = '{3'b111, 3'b000, 1'b0, 24'h000100, 3'b000, 10'd0};
        tbl[9]  = '{3'b111, 3'b000, 1'b0, 24'h010201, 3'b111, 10'd3};
        tbl[10] = '{3'b111, 3'b000, 1'b0, 24'h010201, 3'b000, 10'd3};
        tbl[11] = '{3'b000, 3'b000, 1'b0, 24'h010201, 3'b000, 10'd3};
        tbl[12] = '{3'b100, 3'b000, 1'b0, 24'h010201, 3'b000, 10'd3};
        tbl[13] = '{3'b100, 3'b000, 1'b1, 24'h020201, 3'b100, 10'd0};
        tbl[14] = '{3'b000, 3'b000, 1'b0, 24'h020201, 3'b000, 10'd0};

        model_reset();
        #12;
        chk_zero("reset");
        reset_n = 1'b1;
        #10;

        for (int k = 0; k < 15; k++) begin
            step(tbl[k].s, tbl[k].c, tbl[k].ct);
            chk($sformatf("tbl%0d_cnt", k), 32'(car_cnt), 32'(tbl[k].cnt));
            chk($sformatf("tbl%0d_evt", k), 32'(car_evt), 32'(tbl[k].evt));
            chk($sformatf("tbl%0d_total", k), 32'(total_cnt), 32'(tbl[k].tot));
        end

        step(3'b000, 3'b001, 1'b0);
        chk("clr_lane0", 32'(car_cnt[0 +: CW]), 0);
        for (int k = 0; k < 7; k++) begin
            step(3'b001, 3'b000, 1'b0);
            step(3'b001, 3'b000, 1'b0);
            step(3'b000, 3'b000, 1'b0);
        end
        chk("lane0_seven", 32'(car_cnt[0 +: CW]), 7);
        tot0 = int'(total_cnt);
        step(3'b001, 3'b000, 1'b0);
        step(3'b001, 3'b001, 1'b0);
        chk("clr_evt_cnt", 32'(car_cnt[0 +: CW]), 0);
        chk("clr_evt_ovf", 32'(ovf[0]), 0);
        chk("clr_evt_pulse", 32'(car_evt[0]), 1);
        chk("clr_evt_total", 32'(total_cnt), 32'(tot0 + 1));
        step(3'b001, 3'b001, 1'b0);
        chk("occ_clr_no_recount", 32'(car_evt[0]), 0);
        step(3'b001, 3'b000, 1'b0);
        chk("occ_hold_cnt", 32'(car_cnt[0 +: CW]), 0);
        step(3'b000, 3'b000, 1'b0);

        step(3'b000, 3'b100, 1'b0);
        for (int k = 1; k <= 257; k++) begin
            step(3'b100, 3'b000, 1'b0);
            step(3'b100, 3'b000, 1'b0);
            step(3'b000, 3'b000, 1'b0);
            if (k == 255) begin
                chk("sat255_cnt", 32'(car_cnt[2*CW +: CW]), 255);
                chk("sat255_ovf", 32'(ovf[2]), 0);
                chk("wrap255_cnt", 32'(car_cnt_w[2*CW +: CW]), 255);
                chk("wrap255_ovf", 32'(ovf_w[2]), 0);
            end else if (k == 256) begin
                chk("sat256_cnt", 32'(car_cnt[2*CW +: CW]), 255);
                chk("sat256_ovf", 32'(ovf[2]), 1);
                chk("wrap256_cnt", 32'(car_cnt_w[2*CW +: CW]), 0);
                chk("wrap256_ovf", 32'(ovf_w[2]), 1);
            end
        end
        chk("sat257_cnt", 32'(car_cnt[2*CW +: CW]), 255);
        chk("sat257_ovf", 32'(ovf[2]), 1);
        chk("wrap257_cnt", 32'(car_cnt_w[2*CW +: CW]), 1);
        chk("wrap257_ovf", 32'(ovf_w[2]), 1);
        step(3'b000, 3'b000, 1'b0);
        chk("ovf_sticky", 32'(ovf[2]), 1);
        step(3'b000, 3'b100, 1'b0);
        chk("ovf_clr", 32'(ovf[2]), 0);
        chk("ovf_clr_w", 32'(ovf_w[2]), 0);

        for (int k = 0; k < 350; k++) begin
            step(3'b111, 3'b000, 1'b0);
            step(3'b111, 3'b000, 1'b0);
            step(3'b000, 3'b000, 1'b0);
        end
        chk("total_sat", 32'(total_cnt), TMAX);
        chk("total_sat_w", 32'(total_cnt_w), TMAX);
        compare_model();

        step(3'b001, 3'b000, 1'b0);
        #2 reset_n = 1'b0;
        #1 chk_zero("async_reset");
        model_reset();
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        step(3'b001, 3'b000, 1'b0);
        chk("post_reset_edge1_cnt", 32'(car_cnt[0 +: CW]), 0);
        chk("post_reset_edge1_evt", 32'(car_evt[0]), 0);
        step(3'b001, 3'b000, 1'b0);
        chk("post_reset_edge2_cnt", 32'(car_cnt[0 +: CW]), 1);
        chk("post_reset_edge2_evt", 32'(car_evt[0]), 1);

        rs = '0;
        for (int k = 0; k < 2000; k++) begin
            logic [NL-1:0] rc;
            for (int i = 0; i < NL; i++) begin
                if ($urandom_range(0, 2) == 0) rs[i] = ~rs[i];
                rc[i] = ($urandom_range(0, 15) == 0);
            end
            step(rs, rc, $urandom_range(0, 31) == 0);
            compare_model();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/lane_car_counter.md
LANE_CAR_COUNTER -- requirements
Module: lane_car_counter

Interface
REQ-001 SHALL have parameter NUM_LANES, default 3: number of independent sensor lanes (1..16).
REQ-002 SHALL have parameter CNT_W, default 8: per-lane count width (2..16).
REQ-003 SHALL have parameter MIN_HIGH, default 2: consecutive high samples needed to qualify a vehicle (1..255).
REQ-004 SHALL have parameter SATURATE, default 1: 1 = lane counts saturate at max; 0 = lane counts wrap.
REQ-005 SHALL have parameter TOT_W, default CNT_W+2: width of the all-lane total counter.
REQ-006 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-007 SHALL have port reset_n, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have port sensor, input, NUM_LANES: per-lane vehicle presence, level, high = occupied.
REQ-009 SHALL have port clr, input, NUM_LANES: per-lane synchronous clear of the count and overflow flag.
REQ-010 SHALL have port clr_total, input, 1: synchronous clear of total_cnt.
REQ-011 SHALL have port car_cnt, output, NUM_LANES*CNT_W: packed lane counts, lane i at bits [i*CNT_W +: CNT_W].
REQ-012 SHALL have port car_evt, output, NUM_LANES: one-cycle pulse per qualified vehicle.
REQ-013 SHALL have port ovf, output, NUM_LANES: sticky per-lane overflow flag.
REQ-014 SHALL have port total_cnt, output, TOT_W: count of qualified vehicles across all lanes.

Function
REQ-015 Each lane SHALL run a 3-state FSM: IDLE, QUAL, OCCUPIED.
REQ-016 In IDLE, a high sample SHALL load qual count = 1; if MIN_HIGH = 1, go to OCCUPIED and count; otherwise go to QUAL.
REQ-017 In QUAL, each further high sample SHALL increment qual count; at MIN_HIGH it goes to OCCUPIED and counts; a low sample returns it to IDLE without counting (glitch rejection).
REQ-018 In OCCUPIED, the lane SHALL NOT count again; a low sample returns it to IDLE.
REQ-019 The count SHALL take effect at the MIN_HIGH-th consecutive sampling edge: car_evt is high for exactly the following cycle and car_cnt shows the incremented value from that edge.
REQ-020 With SATURATE = 1, an event at all-ones SHALL hold the count at all-ones and set ovf.
REQ-021 With SATURATE = 0, an event at all-ones SHALL wrap the count to 0 and set ovf.
REQ-022 ovf SHALL stay set until clr or reset.
REQ-023 clr[i] SHALL force lane i count = 0 and ovf = 0, with priority over a same-cycle event; car_evt[i] and total_cnt still register that event.
REQ-024 total_cnt SHALL add the popcount of same-cycle lane events and SHALL saturate at all-ones regardless of SATURATE.
REQ-025 clr_total SHALL force total_cnt = 0 and discard same-cycle events.
REQ-026 A clr asserted while a lane is in QUAL or OCCUPIED SHALL NOT change the FSM state.

Reset
REQ-027 reset_n low SHALL asynchronously set all FSMs to IDLE, all qual counts to 0, and car_cnt, car_evt, ovf and total_cnt to 0.
REQ-028 A vehicle part-way through qualification when reset asserts SHALL be dropped.
REQ-029 A sensor already high at reset release SHALL be qualified as a new vehicle after MIN_HIGH samples.

Configuration
REQ-030 Macro LANE_CNT_SYNC_EN defined: each sensor bit SHALL pass through a 2-flop synchroniser, reset to 0, before the FSM; all latencies grow by 2 cycles.
REQ-031 Macro LANE_CNT_SYNC_EN undefined: sensor SHALL feed the FSM directly, with the latency in REQ-019.

Structure
REQ-032 Package lane_cnt_pkg SHALL hold the lane FSM state typedef (IDLE, QUAL, OCCUPIED) and the parameter limit constants.
REQ-033 Sub-module lane_qual (FSM, qual counter, lane count, ovf) SHALL be instantiated NUM_LANES times by generate.
REQ-034 The top level SHALL hold only the synchronisers, the popcount and total_cnt.

Verification (defaults, sync disabled)
REQ-035 Lane 0 sensor high 1 cycle, then low -> no car_evt; car_cnt[0] stays 0.
REQ-036 Lane 1 sensor high 5 cycles -> car_evt[1] pulses once, 2nd edge after rise; car_cnt lane 1 = 1; total_cnt = 1.
REQ-037 All 3 lanes high together for 3 cycles -> 3 car_evt pulses in one cycle; total_cnt = 3.
REQ-038 Lane 2 qualified 257 times, SATURATE = 1 -> count = 255, ovf[2] = 1; same with SATURATE = 0 -> count = 1, ovf[2] = 1.
REQ-039 clr[0] in the same cycle as a lane 0 event with count 7 -> count = 0, ovf[0] = 0, car_evt[0] = 1, total_cnt increments.
REQ-040 reset_n low while lane 0 is in QUAL, sensor held high -> outputs 0; after release, count = 1 after 2 edges.
